// File: rtl/u712_pkg.sv
// Shared types and constants for the U712 68040-to-chipset bus sizer.
// Line bursting is selected by U712_LINE_BURST_EN in the files that use it.
package u712_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [3:0] WCNT_SINGLE = 4'd1;
    localparam logic [3:0] WCNT_LONG   = 4'd2;
    localparam logic [3:0] WCNT_LINE   = 4'd8;

    // 68040 line wrap: toggle the word bit, carry into the longword index mod 4
    function automatic logic [2:0] next_word_addr(input logic [2:0] wa);
        next_word_addr = {wa[2:1] + {1'b0, wa[0]}, ~wa[0]};
    endfunction

endpackage

// File: rtl/u712_chip_sizer_if.sv
// CPU-side and chipset-side signals of the bus sizer, grouped for port lists.
interface u712_chip_sizer_if;

    logic       TSn;
    logic       CPU_CYCLE;
    logic [3:0] A;
    logic [1:0] SIZ;
    logic       RnW;
    logic       CHIP_ACK;

    logic       CHIP_REQ;
    logic [2:0] CHIP_A;
    logic       CHIP_RnW;
    logic       UDS;
    logic       LDS;
    logic       LATCH_HI;
    logic       LATCH_LO;
    logic       DRIVE_HI;
    logic       TAn;
    logic       TBIn;
    logic       BUSY;

    modport slave (
        input  TSn, CPU_CYCLE, A, SIZ, RnW, CHIP_ACK,
        output CHIP_REQ, CHIP_A, CHIP_RnW, UDS, LDS, LATCH_HI, LATCH_LO,
               DRIVE_HI, TAn, TBIn, BUSY
    );

    modport master (
        output TSn, CPU_CYCLE, A, SIZ, RnW, CHIP_ACK,
        input  CHIP_REQ, CHIP_A, CHIP_RnW, UDS, LDS, LATCH_HI, LATCH_LO,
               DRIVE_HI, TAn, TBIn, BUSY
    );

endinterface

// File: rtl/u712_strobe_decode.sv
// Maps CPU size and A[0] to data strobes and the number of chip words.
// U712_LINE_BURST_EN: a line is 8 words; otherwise it is sized like a long.
module u712_strobe_decode
    import u712_pkg::*;
(
    input  logic [1:0] siz,
    input  logic       a0,
    output logic       uds,
    output logic       lds,
    output logic [3:0] wcnt
);

    always_comb begin
        uds  = 1'b1;
        lds  = 1'b1;
        wcnt = WCNT_SINGLE;
        case (siz)
            SIZ_BYTE: begin
                uds = ~a0;
                lds = a0;
            end
            SIZ_LONG: wcnt = WCNT_LONG;
            SIZ_LINE: begin
`ifdef U712_LINE_BURST_EN
                wcnt = WCNT_LINE;
`else
                wcnt = WCNT_LONG;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/u712_chip_sizer.sv
// Splits 68040 transfers into 16-bit chipset cycles (REQ/ACK) and returns TAn/TBIn.
// U712_LINE_BURST_EN: run full 8-word lines; otherwise lines end after one long with TBIn.
module u712_chip_sizer
    import u712_pkg::*;
(
    input  logic                CLK40,
    input  logic                RESET,
    u712_chip_sizer_if.slave    bus
);

`ifdef U712_LINE_BURST_EN
    localparam logic LINE_BURST = 1'b1;
`else
    localparam logic LINE_BURST = 1'b0;
`endif

    state_t     state;
    logic [3:0] wcnt;
    logic [2:0] chip_a;
    logic       chip_rnw;
    logic       uds, lds;
    logic       uds_q, lds_q;
    logic       single, line;
    logic       req, drive_hi, tan, tbin;

    logic       dec_uds, dec_lds;
    logic [3:0] dec_wcnt;
    logic       start;
    logic       is_single;
    logic [2:0] start_a;
    logic [2:0] next_a;

    u712_strobe_decode u_strobe (
        .siz  (bus.SIZ),
        .a0   (bus.A[0]),
        .uds  (dec_uds),
        .lds  (dec_lds),
        .wcnt (dec_wcnt)
    );

    assign start     = (state == IDLE) && !bus.TSn && bus.CPU_CYCLE;
    assign is_single = (bus.SIZ == SIZ_BYTE) || (bus.SIZ == SIZ_WORD);
    assign start_a   = is_single ? bus.A[3:1] : {bus.A[3:2], 1'b0};
    assign next_a    = next_word_addr(chip_a);

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state    <= IDLE;
            wcnt     <= '0;
            chip_a   <= '0;
            chip_rnw <= 1'b1;
            uds      <= 1'b0;
            lds      <= 1'b0;
            uds_q    <= 1'b0;
            lds_q    <= 1'b0;
            single   <= 1'b0;
            line     <= 1'b0;
            req      <= 1'b0;
            drive_hi <= 1'b1;
            tan      <= 1'b1;
            tbin     <= 1'b1;
        end else begin
            tan  <= 1'b1;
            tbin <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state    <= REQ;
                    req      <= 1'b1;
                    wcnt     <= dec_wcnt;
                    chip_a   <= start_a;
                    drive_hi <= ~start_a[0];
                    chip_rnw <= bus.RnW;
                    uds      <= dec_uds;
                    lds      <= dec_lds;
                    uds_q    <= dec_uds;
                    lds_q    <= dec_lds;
                    single   <= is_single;
                    line     <= (bus.SIZ == SIZ_LINE);
                end
                REQ: if (bus.CHIP_ACK) begin
                    state    <= GAP;
                    req      <= 1'b0;
                    uds      <= 1'b0;
                    lds      <= 1'b0;
                    wcnt     <= wcnt - 4'd1;
                    chip_a   <= next_a;
                    drive_hi <= ~next_a[0];
                    // a longword completes on the odd word, or on the only word
                    if (single || chip_a[0]) begin
                        tan  <= 1'b0;
                        tbin <= ~(line && !LINE_BURST);
                    end
                end
                GAP: begin
                    if (wcnt != 4'd0) begin
                        state <= REQ;
                        req   <= 1'b1;
                        uds   <= uds_q;
                        lds   <= lds_q;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CHIP_REQ = req;
    assign bus.CHIP_A   = chip_a;
    assign bus.CHIP_RnW = chip_rnw;
    assign bus.UDS      = uds;
    assign bus.LDS      = lds;
    assign bus.DRIVE_HI = drive_hi;
    assign bus.TAn      = tan;
    assign bus.TBIn     = tbin;
    assign bus.BUSY     = (state != IDLE);
    // read data is captured at the ACK edge, so the latch enables are Mealy
    assign bus.LATCH_HI = (state == REQ) && bus.CHIP_ACK && chip_rnw && !chip_a[0];
    assign bus.LATCH_LO = (state == REQ) && bus.CHIP_ACK && chip_rnw &&  chip_a[0];

endmodule

// File: tb/tb_u712_chip_sizer.sv
// Randomized bench for u712_chip_sizer against a word-list model of each CPU transfer.
module tb_u712_chip_sizer;
    import u712_pkg::*;

`ifdef U712_LINE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic CLK40 = 1'b0;
    logic RESET;
    always #5 CLK40 = ~CLK40;

    u712_chip_sizer_if bus();

    u712_chip_sizer dut (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req"},   bus.CHIP_REQ, 0);
        chk({tag, ".busy"},  bus.BUSY, 0);
        chk({tag, ".tan"},   bus.TAn, 1);
        chk({tag, ".tbin"},  bus.TBIn, 1);
        chk({tag, ".strb"},  {bus.UDS, bus.LDS}, 0);
        chk({tag, ".latch"}, {bus.LATCH_HI, bus.LATCH_LO}, 0);
    endtask

    // One CPU transfer; wt < 0 picks a random 0..3 wait per word
    task automatic xfer(input logic [3:0] a, input logic [1:0] siz, input logic rnw, input int wt);
        bit         single;
        int         nw;
        logic [2:0] start_a, wa;
        logic       eu, el, etan, etbin;
        int         w;
        single  = (siz == SIZ_BYTE) || (siz == SIZ_WORD);
        nw      = single ? 1 : ((siz == SIZ_LINE && BURST) ? 8 : 2);
        start_a = single ? a[3:1] : {a[3:2], 1'b0};
        eu      = (siz == SIZ_BYTE) ? !a[0] : 1'b1;
        el      = (siz == SIZ_BYTE) ?  a[0] : 1'b1;

        @(posedge CLK40); #1;
        bus.TSn = 1'b0; bus.CPU_CYCLE = 1'b1;
        bus.A = a; bus.SIZ = siz; bus.RnW = rnw;
        @(posedge CLK40); #1;
        // scramble the CPU bus after TS so capture is what gets tested
        bus.TSn = 1'b1; bus.CPU_CYCLE = 1'($urandom);
        bus.A = 4'($urandom); bus.SIZ = 2'($urandom); bus.RnW = 1'($urandom);

        for (int k = 0; k < nw; k++) begin
            wa = start_a + 3'(k);
            @(negedge CLK40);
            chk("req",     bus.CHIP_REQ, 1);
            chk("chip_a",  bus.CHIP_A, wa);
            chk("strb",    {bus.UDS, bus.LDS}, {eu, el});
            chk("rnw",     bus.CHIP_RnW, rnw);
            chk("drv_hi",  bus.DRIVE_HI, !wa[0]);
            chk("busy",    bus.BUSY, 1);
            chk("tan_req", bus.TAn, 1);
            w = (wt < 0) ? int'($urandom_range(3, 0)) : wt;
            repeat (w) begin
                @(posedge CLK40); #1;
                chk("req_wait", {bus.CHIP_REQ, bus.LATCH_HI, bus.LATCH_LO}, 3'b100);
            end
            bus.CHIP_ACK = 1'b1;
            #1;
            chk("latch", {bus.LATCH_HI, bus.LATCH_LO}, {rnw && !wa[0], rnw && wa[0]});
            @(posedge CLK40); #1;
            bus.CHIP_ACK = 1'b0;
            etan  = !(single || wa[0]);
            etbin = !(!etan && siz == SIZ_LINE && !BURST);
            @(negedge CLK40);
            chk("gap_req",  bus.CHIP_REQ, 0);
            chk("gap_strb", {bus.UDS, bus.LDS}, 0);
            chk("gap_busy", bus.BUSY, 1);
            chk("tan",      bus.TAn, etan);
            chk("tbin",     bus.TBIn, etbin);
            @(posedge CLK40); #1;
        end
        @(negedge CLK40);
        chk_idle("done");
    endtask

    initial begin
        RESET = 1'b1;
        bus.TSn = 1'b1; bus.CPU_CYCLE = 1'b0; bus.A = '0;
        bus.SIZ = '0; bus.RnW = 1'b1; bus.CHIP_ACK = 1'b0;
        repeat (2) @(posedge CLK40);
        #1 RESET = 1'b0;

        @(negedge CLK40);
        chk_idle("rst");
        chk("rst.chip_a", bus.CHIP_A, 0);
        chk("rst.rnw",    bus.CHIP_RnW, 1);
        chk("rst.drv_hi", bus.DRIVE_HI, 1);

        // stray ACK in IDLE, then TS to non-chip space: nothing moves
        @(posedge CLK40); #1 bus.CHIP_ACK = 1'b1;
        #1 chk("idle_ack.latch", {bus.LATCH_HI, bus.LATCH_LO}, 0);
        @(posedge CLK40); #1 bus.CHIP_ACK = 1'b0;
        bus.TSn = 1'b0; bus.CPU_CYCLE = 1'b0; bus.SIZ = SIZ_LONG;
        @(posedge CLK40); #1 bus.TSn = 1'b1;
        @(negedge CLK40);
        chk_idle("ign");
        chk("ign.chip_a", bus.CHIP_A, 0);

        xfer(4'h3, SIZ_BYTE, 1'b1, 2);
        xfer(4'h4, SIZ_LONG, 1'b0, 0);
        xfer(4'h8, SIZ_LINE, 1'b1, 0);
        xfer(4'hE, SIZ_LINE, 1'b1, 1);

        // reset during the second word of a long
        @(posedge CLK40); #1;
        bus.TSn = 1'b0; bus.CPU_CYCLE = 1'b1; bus.A = 4'h4; bus.SIZ = SIZ_LONG; bus.RnW = 1'b1;
        @(posedge CLK40); #1 bus.TSn = 1'b1; bus.CHIP_ACK = 1'b1;
        @(posedge CLK40); #1 bus.CHIP_ACK = 1'b0;
        @(posedge CLK40); #1;
        chk("rst2.chip_a", bus.CHIP_A, 3'b011);
        RESET = 1'b1;
        @(posedge CLK40); #1 RESET = 1'b0;
        @(negedge CLK40);
        chk_idle("rst2");
        xfer(4'h6, SIZ_WORD, 1'b0, 1);

        for (int i = 0; i < 40; i++)
            xfer(4'($urandom), 2'($urandom), 1'($urandom), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
